exception_unit: RTL and testbench

Trap-control stage that sits directly upstream of the `csr` block. It watches the instruction at the commit point, arbitrates synchronous exceptions, interrupts and `mret`, and produces the `we_exc` write bundle (mcause/mepc/mtval/mstatus) the CSR file consumes. It uses the CSR file's `mtvec`, `mepc` and `mstatus` outputs to redirect the fetch PC and flush the pipeline.

---
 rtl/exception_pkg.sv | 68 ++++++
 rtl/exception_prio.sv | 82 ++++++++
 rtl/exception_unit.sv | 182 ++++++++++++++++++
 tb/tb_exception_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_pkg.sv
// ============================================================================
// Module      : exception_pkg
// Description : Shared constants, types and mstatus helpers for the trap unit.
//               - Cause codes (bit 31 set for interrupts)
//               - mstatus / mie bit indices, mtvec mode encodings
//               - FSM state type
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exception_pkg;

  // Synchronous exception cause codes
  localparam logic [31:0] CAUSE_INST_MISALIGN = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL       = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT    = 32'd3;
  localparam logic [31:0] CAUSE_LD_MISALIGN   = 32'd4;
  localparam logic [31:0] CAUSE_ST_MISALIGN   = 32'd6;
  localparam logic [31:0] CAUSE_ECALL_M       = 32'd11;

  // Interrupt cause codes (bit 31 marks an interrupt)
  localparam logic [31:0] CAUSE_IRQ_SW        = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TIMER     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT       = 32'h8000_000B;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie fields
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  // mtvec modes; 2 and 3 behave as direct
  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // mstatus on trap entry: stash MIE in MPIE, disable interrupts, MPP = M
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: restore MIE from MPIE, set MPIE, MPP stays M-only
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exception_prio.sv
// ============================================================================
// Module      : exception_prio
// Description : Combinational trap arbiter. Interrupts beat exceptions;
//               within each class a fixed order picks the cause and mtval.
// Ports       : exc_* flags, irq_* requests with their mie enables, global
//               mie (mstatus.MIE), pc/instr/addr for mtval selection;
//               outputs take, is_int, cause, tval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_prio
  import exception_pkg::*;
(
  input  logic        exc_inst_misalign,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_ld_misalign,
  input  logic        exc_st_misalign,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        en_ext,
  input  logic        en_sw,
  input  logic        en_timer,
  input  logic        global_ie,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] addr,
  output logic        take,
  output logic        is_int,
  output logic [31:0] cause,
  output logic [31:0] tval
);

  logic ext_p;
  logic sw_p;
  logic timer_p;
  logic int_pend;
  logic exc_any;

  assign ext_p    = irq_ext & en_ext;
  assign sw_p     = irq_sw & en_sw;
  assign timer_p  = irq_timer & en_timer;
  assign int_pend = global_ie & (ext_p | sw_p | timer_p);
  assign exc_any  = exc_inst_misalign | exc_illegal | exc_ebreak |
                    exc_ecall | exc_ld_misalign | exc_st_misalign;

  always_comb begin
    take   = int_pend | exc_any;
    is_int = 1'b0;
    cause  = '0;
    tval   = '0;
    if (int_pend) begin
      is_int = 1'b1;
      if (ext_p)      cause = CAUSE_IRQ_EXT;
      else if (sw_p)  cause = CAUSE_IRQ_SW;
      else            cause = CAUSE_IRQ_TIMER;
    end else if (exc_inst_misalign) begin
      cause = CAUSE_INST_MISALIGN;
      tval  = addr;
    end else if (exc_illegal) begin
      cause = CAUSE_ILLEGAL;
      tval  = instr;
    end else if (exc_ebreak) begin
      cause = CAUSE_BREAKPOINT;
      tval  = pc;
    end else if (exc_ecall) begin
      cause = CAUSE_ECALL_M;
    end else if (exc_ld_misalign) begin
      cause = CAUSE_LD_MISALIGN;
      tval  = addr;
    end else if (exc_st_misalign) begin
      cause = CAUSE_ST_MISALIGN;
      tval  = addr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exception_unit.sv
// ============================================================================
// Module      : exception_unit
// Description : Trap-control stage feeding the CSR file. Arbitrates
//               interrupts / exceptions / mret at commit, emits the
//               we_exc CSR bundle, redirects fetch and holds a flush window.
// Ports       : clk_i, rst_i; commit info (valid_i, pc_i, instr_i, addr_i,
//               exc_* flags, mret_i); irq_* levels; CSR values (mstatus_i,
//               mie_i, mtvec_i, mepc_i, mcause_i, mtval_i); outputs
//               we_exc_o + bundle, redirect_o/redirect_pc_o, flush_o, busy_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_unit
  import exception_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] addr_i,
  input  logic        exc_inst_misalign_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        exc_ld_misalign_i,
  input  logic        exc_st_misalign_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mtval_i,
  output logic        we_exc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic [31:0] mstatus_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        busy_o
);

  localparam int             CW     = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(FLUSH_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        take;
  logic        is_int;
  logic [31:0] cause;
  logic [31:0] tval;
  logic [31:0] vec_base;
  logic [31:0] trap_pc;

  logic        we_d, redir_d, flush_d, busy_d;
  logic [31:0] mcause_d, mepc_d, mtval_d, mstatus_d, rpc_d;

  // Bits deliberately not consumed by this block
  logic unused_bits;
  assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], cause[31:30]};

  exception_prio u_prio (
    .exc_inst_misalign (exc_inst_misalign_i),
    .exc_illegal       (exc_illegal_i),
    .exc_ebreak        (exc_ebreak_i),
    .exc_ecall         (exc_ecall_i),
    .exc_ld_misalign   (exc_ld_misalign_i),
    .exc_st_misalign   (exc_st_misalign_i),
    .irq_ext           (irq_ext_i),
    .irq_sw            (irq_sw_i),
    .irq_timer         (irq_timer_i),
    .en_ext            (mie_i[MIE_MEIE]),
    .en_sw             (mie_i[MIE_MSIE]),
    .en_timer          (mie_i[MIE_MTIE]),
    .global_ie         (mstatus_i[MSTATUS_MIE]),
    .pc                (pc_i),
    .instr             (instr_i),
    .addr              (addr_i),
    .take              (take),
    .is_int            (is_int),
    .cause             (cause),
    .tval              (tval)
  );

  // Vectored mode only applies to interrupts; offset is 4*cause[30:0] mod 2^32
  assign vec_base = {mtvec_i[31:2], 2'b00};
  assign trap_pc  = (is_int && (mtvec_i[1:0] == MTVEC_VECTORED))
                    ? vec_base + {cause[29:0], 2'b00}
                    : vec_base;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    redir_d   = 1'b0;
    flush_d   = flush_o;
    busy_d    = busy_o;
    mcause_d  = mcause_o;
    mepc_d    = mepc_o;
    mtval_d   = mtval_o;
    mstatus_d = mstatus_o;
    rpc_d     = redirect_pc_o;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && (take || mret_i)) begin
          state_d = ST_FLUSH;
          cnt_d   = CW'(1);
          we_d    = 1'b1;
          redir_d = 1'b1;
          flush_d = 1'b1;
          busy_d  = 1'b1;
          if (take) begin
            mcause_d  = cause;
            mepc_d    = pc_i;
            mtval_d   = tval;
            mstatus_d = trap_mstatus(mstatus_i);
            rpc_d     = trap_pc;
          end else begin
            mcause_d  = mcause_i;
            mepc_d    = mepc_i;
            mtval_d   = mtval_i;
            mstatus_d = mret_mstatus(mstatus_i);
            rpc_d     = {mepc_i[31:2], 2'b00};
          end
        end
      end
      ST_FLUSH: begin
        // Counter holds the index of the flush cycle currently in progress
        if (cnt_q == C_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      we_exc_o      <= 1'b0;
      redirect_o    <= 1'b0;
      flush_o       <= 1'b0;
      busy_o        <= 1'b0;
      mcause_o      <= '0;
      mepc_o        <= '0;
      mtval_o       <= '0;
      mstatus_o     <= '0;
      redirect_pc_o <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_exc_o      <= we_d;
      redirect_o    <= redir_d;
      flush_o       <= flush_d;
      busy_o        <= busy_d;
      mcause_o      <= mcause_d;
      mepc_o        <= mepc_d;
      mtval_o       <= mtval_d;
      mstatus_o     <= mstatus_d;
      redirect_pc_o <= rpc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exception_unit.sv
// ============================================================================
// Module      : tb_exception_unit
// Description : Self-checking bench for exception_unit. Expected CSR bundles
//               are queued when stimulus is applied and compared when the
//               write strobe appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, instr_i, addr_i;
  logic        exc_inst_misalign_i, exc_illegal_i, exc_ebreak_i;
  logic        exc_ecall_i, exc_ld_misalign_i, exc_st_misalign_i;
  logic        mret_i, irq_ext_i, irq_sw_i, irq_timer_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i, mtval_i;
  logic        we_exc_o, redirect_o, flush_o, busy_o;
  logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] mstatus;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exception_unit #(.FLUSH_CYCLES(2)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .instr_i             (instr_i),
    .addr_i              (addr_i),
    .exc_inst_misalign_i (exc_inst_misalign_i),
    .exc_illegal_i       (exc_illegal_i),
    .exc_ebreak_i        (exc_ebreak_i),
    .exc_ecall_i         (exc_ecall_i),
    .exc_ld_misalign_i   (exc_ld_misalign_i),
    .exc_st_misalign_i   (exc_st_misalign_i),
    .mret_i              (mret_i),
    .irq_ext_i           (irq_ext_i),
    .irq_sw_i            (irq_sw_i),
    .irq_timer_i         (irq_timer_i),
    .mstatus_i           (mstatus_i),
    .mie_i               (mie_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .mcause_i            (mcause_i),
    .mtval_i             (mtval_i),
    .we_exc_o            (we_exc_o),
    .mcause_o            (mcause_o),
    .mepc_o              (mepc_o),
    .mtval_o             (mtval_o),
    .mstatus_o           (mstatus_o),
    .redirect_o          (redirect_o),
    .redirect_pc_o       (redirect_pc_o),
    .flush_o             (flush_o),
    .busy_o              (busy_o)
  );

  task automatic clear_inputs();
    valid_i = 0; pc_i = 0; instr_i = 0; addr_i = 0;
    exc_inst_misalign_i = 0; exc_illegal_i = 0; exc_ebreak_i = 0;
    exc_ecall_i = 0; exc_ld_misalign_i = 0; exc_st_misalign_i = 0;
    mret_i = 0; irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
    mstatus_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0; mcause_i = 0; mtval_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1;
    step();
    step();
    rst_i = 0;
    checks++;
    if ({we_exc_o, redirect_o, flush_o, busy_o, mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b rd=%b fl=%b bz=%b cause=%h epc=%h tval=%h ms=%h rpc=%h, want all zero",
               we_exc_o, redirect_o, flush_o, busy_o, mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    clear_inputs();
    pc_i = 32'h100; instr_i = 32'hFFFF_FFFF; mtvec_i = 32'h200; mstatus_i = 32'h8;
    exc_illegal_i = 1; valid_i = 1;
    sb.push_back('{32'd2, 32'h100, 32'hFFFF_FFFF, 32'h1880, 32'h200});
    step();
    valid_i = 0; exc_illegal_i = 0;
    checks++;
    if ({we_exc_o, redirect_o, flush_o, busy_o} !== 4'b1111) begin
      failures++;
      $display("FAIL illegal_strobes: got we/rd/fl/bz=%b, want 1111", {we_exc_o, redirect_o, flush_o, busy_o});
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL illegal_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step();
    checks++;
    if ({we_exc_o, redirect_o, flush_o, busy_o} !== 4'b0011) begin
      failures++;
      $display("FAIL illegal_flush2: got we/rd/fl/bz=%b, want 0011", {we_exc_o, redirect_o, flush_o, busy_o});
    end
    step();
    checks++;
    if ({we_exc_o, redirect_o, flush_o, busy_o} !== 4'b0000) begin
      failures++;
      $display("FAIL illegal_flush_end: got we/rd/fl/bz=%b, want 0000", {we_exc_o, redirect_o, flush_o, busy_o});
    end
  endtask

  task automatic test_timer_vectored();
    exp_t e;
    clear_inputs();
    pc_i = 32'h400; addr_i = 32'h1235; mtvec_i = 32'h301; mstatus_i = 32'h8;
    mie_i = 32'h80; irq_timer_i = 1; exc_ld_misalign_i = 1; valid_i = 1;
    sb.push_back('{32'h8000_0007, 32'h400, 32'h0, 32'h1880, 32'h31C});
    step();
    valid_i = 0; exc_ld_misalign_i = 0; irq_timer_i = 0;
    checks++;
    if (we_exc_o !== 1'b1) begin
      failures++;
      $display("FAIL timer_strobe: got we=%b, want 1", we_exc_o);
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL timer_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step(); step();
  endtask

  task automatic test_mret();
    exp_t e;
    clear_inputs();
    mstatus_i = 32'h1880; mepc_i = 32'h104; mcause_i = 32'h2; mtval_i = 32'hDEAD_BEEF;
    mtvec_i = 32'h200; mret_i = 1; valid_i = 1; pc_i = 32'h300;
    sb.push_back('{32'h2, 32'h104, 32'hDEAD_BEEF, 32'h1888, 32'h104});
    step();
    valid_i = 0; mret_i = 0;
    checks++;
    if ({we_exc_o, redirect_o} !== 2'b11) begin
      failures++;
      $display("FAIL mret_strobe: got we/rd=%b, want 11", {we_exc_o, redirect_o});
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL mret_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step(); step();
  endtask

  // Exception order plus vectored mtvec that must not apply to exceptions
  task automatic test_exc_priority();
    exp_t e;
    clear_inputs();
    pc_i = 32'h500; addr_i = 32'h2002; mtvec_i = 32'h301; mstatus_i = 32'h0;
    exc_ecall_i = 1; exc_inst_misalign_i = 1; valid_i = 1;
    sb.push_back('{32'h0, 32'h500, 32'h2002, 32'h1800, 32'h300});
    step();
    valid_i = 0; exc_ecall_i = 0; exc_inst_misalign_i = 0;
    checks++;
    if (we_exc_o !== 1'b1) begin
      failures++;
      $display("FAIL prio_strobe: got we=%b, want 1", we_exc_o);
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL prio_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step(); step();
  endtask

  // Requests during FLUSH are dropped; a held irq is taken once IDLE again
  task automatic test_flush_ignore();
    exp_t e;
    clear_inputs();
    pc_i = 32'h600; mtvec_i = 32'h201; mstatus_i = 32'h8; mie_i = 32'h800;
    exc_ecall_i = 1; valid_i = 1;
    sb.push_back('{32'd11, 32'h600, 32'h0, 32'h1880, 32'h200});
    step();
    exc_ecall_i = 0; exc_illegal_i = 1; irq_ext_i = 1; pc_i = 32'h700; instr_i = 32'h1234_5678;
    checks++;
    if (we_exc_o !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_first: got we=%b, want 1", we_exc_o);
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL back_to_back_first_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (we_exc_o !== 1'b0) begin
        failures++;
        $display("FAIL flush_ignore_cycle%0d: got we=%b, want 0", i, we_exc_o);
      end
    end
    sb.push_back('{32'h8000_000B, 32'h700, 32'h0, 32'h1880, 32'h22C});
    step();
    valid_i = 0; exc_illegal_i = 0; irq_ext_i = 0;
    checks++;
    if (we_exc_o !== 1'b1) begin
      failures++;
      $display("FAIL held_irq_strobe: got we=%b, want 1", we_exc_o);
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL held_irq_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step(); step();
  endtask

  // No valid -> nothing taken; MIE=0 gates irqs; sw beats timer
  task automatic test_irq_gating();
    exp_t e;
    clear_inputs();
    mie_i = 32'h88; mstatus_i = 32'h8; irq_sw_i = 1; irq_timer_i = 1; mtvec_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (we_exc_o !== 1'b0) begin
        failures++;
        $display("FAIL novalid_irq%0d: got we=%b, want 0", i, we_exc_o);
      end
    end
    mstatus_i = 32'h0; valid_i = 1; pc_i = 32'h900;
    step();
    checks++;
    if (we_exc_o !== 1'b0) begin
      failures++;
      $display("FAIL mie_gate: got we=%b, want 0", we_exc_o);
    end
    mstatus_i = 32'h8;
    sb.push_back('{32'h8000_0003, 32'h900, 32'h0, 32'h1880, 32'h200});
    step();
    valid_i = 0; irq_sw_i = 0; irq_timer_i = 0;
    checks++;
    if (we_exc_o !== 1'b1) begin
      failures++;
      $display("FAIL sw_irq_strobe: got we=%b, want 1", we_exc_o);
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL sw_irq_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step(); step();
  endtask

  task automatic test_reset_mid_flush();
    exp_t e;
    clear_inputs();
    pc_i = 32'h880; mtvec_i = 32'h200; mstatus_i = 32'h8; exc_ebreak_i = 1; valid_i = 1;
    step();
    valid_i = 0; exc_ebreak_i = 0;
    step();
    rst_i = 1;
    step();
    rst_i = 0;
    checks++;
    if ({we_exc_o, redirect_o, flush_o, busy_o, mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== '0) begin
      failures++;
      $display("FAIL midflush_reset: got we=%b fl=%b bz=%b cause=%h epc=%h tval=%h ms=%h rpc=%h, want all zero",
               we_exc_o, flush_o, busy_o, mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o);
    end
    pc_i = 32'h800; mstatus_i = 32'h0; exc_ecall_i = 1; valid_i = 1;
    sb.push_back('{32'd11, 32'h800, 32'h0, 32'h1800, 32'h200});
    step();
    valid_i = 0; exc_ecall_i = 0;
    checks++;
    if ({we_exc_o, flush_o} !== 2'b11) begin
      failures++;
      $display("FAIL after_reset_strobe: got we/fl=%b, want 11", {we_exc_o, flush_o});
    end
    if (we_exc_o) begin
      e = sb.pop_front();
      checks++;
      if ({mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o} !== e) begin
        failures++;
        $display("FAIL after_reset_bundle: got %h, want %h", {mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o}, e);
      end
    end else void'(sb.pop_front());
    step(); step();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_timer_vectored();
    test_mret();
    test_exc_priority();
    test_flush_ignore();
    test_irq_gating();
    test_reset_mid_flush();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
